// File: rtl/hash_round_ctrl.sv
// Iterative 8-bit compression round controller: loads a 16-byte block, runs
// ROUNDS rounds over a sliding W window, then offers the 24-bit digest.
module hash_round_ctrl #(
   parameter int ROUNDS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] digest,
   output logic        busy
);
   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] A_INIT     = 8'h67;
   localparam logic [7:0] B_INIT     = 8'hEF;
   localparam logic [7:0] C_INIT     = 8'h98;
   localparam logic [7:0] K_TYPE1    = 8'h99;
   localparam logic [7:0] K_TYPE2    = 8'hA1;
   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);
   localparam logic [4:0] HALF_ROUND = 5'(ROUNDS / 2);

   state_t      state_reg, state_next;
   logic [3:0]  byte_cnt_reg, byte_cnt_next;
   logic [4:0]  round_reg, round_next;
   logic [7:0]  a_reg, a_next, b_reg, b_next, c_reg, c_next;
   logic [23:0] digest_reg, digest_next;
   logic [7:0]  w_reg  [16];
   logic [7:0]  w_next [16];

   logic       load_fire, run_step;
   logic [7:0] x_rnd, k_rnd, a_rnd, b_rnd, c_rnd;
   logic [7:0] w_mix, w_fb;

   assign load_fire = (state_reg == LOAD) && in_valid;
   assign run_step  = (state_reg == RUN);

   // First half of the rounds are type-1 (xor mix), second half type-2 (or mix).
   always_comb begin
      if (round_reg >= HALF_ROUND) begin
         x_rnd = a_reg | b_reg;
         k_rnd = K_TYPE2;
      end else begin
         x_rnd = a_reg ^ b_reg;
         k_rnd = K_TYPE1;
      end
      a_rnd = b_reg ^ c_reg;
      b_rnd = {c_reg[3:0], 4'h0};
      c_rnd = x_rnd + k_rnd + w_reg[0];
   end

   assign w_mix = w_reg[13] ^ w_reg[8] ^ w_reg[2] ^ w_reg[0];
   assign w_fb  = {w_mix[6:0], w_mix[7]};

   // Window doubles as the load buffer and, during RUN, the shifting W schedule.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_window
         if (gi < 15) begin : g_shift
            assign w_next[gi] = run_step ? w_reg[gi+1] :
                                (load_fire && byte_cnt_reg == 4'(gi)) ? in_data : w_reg[gi];
         end else begin : g_feedback
            assign w_next[gi] = run_step ? w_fb :
                                (load_fire && byte_cnt_reg == 4'(gi)) ? in_data : w_reg[gi];
         end
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      round_next    = round_reg;
      a_next        = a_reg;
      b_next        = b_reg;
      c_next        = c_reg;
      digest_next   = digest_reg;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      busy          = 1'b0;
      case (state_reg)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               byte_cnt_next = byte_cnt_reg + 4'd1;
               if (byte_cnt_reg == 4'd15) begin
                  state_next = RUN;
                  a_next     = A_INIT;
                  b_next     = B_INIT;
                  c_next     = C_INIT;
                  round_next = '0;
               end
            end
         end
         RUN: begin
            busy       = 1'b1;
            a_next     = a_rnd;
            b_next     = b_rnd;
            c_next     = c_rnd;
            round_next = round_reg + 5'd1;
            if (round_reg == LAST_ROUND) begin
               digest_next = {a_rnd + A_INIT, b_rnd + B_INIT, c_rnd + C_INIT};
               state_next  = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next    = LOAD;
               byte_cnt_next = '0;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= LOAD;
         byte_cnt_reg <= '0;
         round_reg    <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         c_reg        <= '0;
         digest_reg   <= '0;
         for (int i = 0; i < 16; i++) w_reg[i] <= '0;
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         round_reg    <= round_next;
         a_reg        <= a_next;
         b_reg        <= b_next;
         c_reg        <= c_next;
         digest_reg   <= digest_next;
         for (int i = 0; i < 16; i++) w_reg[i] <= w_next[i];
      end
   end

   assign digest = digest_reg;

endmodule

// File: tb/tb_hash_round_ctrl.sv
// Self-checking bench for hash_round_ctrl: one instance with ROUNDS=2 and one
// with ROUNDS=32, checked against a schedule-array reference model.
module tb_hash_round_ctrl;
   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       iv, ordy, ir, ov, bsy;
   logic [1:0][7:0]  idat;
   logic [1:0][23:0] dig;
   logic [7:0]       blk [16];
   logic [23:0]      exp_d;
   int               n_checks = 0;
   int               n_errors = 0;

   always #5 clk = ~clk;

   hash_round_ctrl #(.ROUNDS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .digest(dig[0]), .busy(bsy[0])
   );
   hash_round_ctrl #(.ROUNDS(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .digest(dig[1]), .busy(bsy[1])
   );

   function automatic int rounds_of(input int s);
      return (s == 0) ? 2 : 32;
   endfunction

   // Reference: build the whole W schedule up front, then iterate the rounds.
   function automatic logic [23:0] model(input logic [7:0] m [16], input int rounds);
      logic [7:0] w [32];
      logic [7:0] a, b, c, x, k, t, na, nb, nc;
      for (int i = 0; i < 16; i++) w[i] = m[i];
      for (int i = 16; i < 32; i++) begin
         t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {t[6:0], t[7]};
      end
      a = 8'h67; b = 8'hEF; c = 8'h98;
      for (int r = 0; r < rounds; r++) begin
         if (r < rounds / 2) begin x = a ^ b; k = 8'h99; end
         else begin x = a | b; k = 8'hA1; end
         na = b ^ c;
         nb = c << 4;
         nc = x + k + w[r];
         a = na; b = nb; c = nc;
      end
      return {a + 8'h67, b + 8'hEF, c + 8'h98};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic rand_block();
      for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(255));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; iv = '0; ordy = '0;
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_digest", dig[s], 24'h0);
         chk("rst_out_valid", ov[s], 1'b0);
         chk("rst_busy", bsy[s], 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready0", ir[0], 1'b1);
      chk("rst_in_ready1", ir[1], 1'b1);
   endtask

   // Presents the first n bytes of blk; gap_pct is the chance of idling a cycle.
   task automatic send_block(input int s, input int n, input int gap_pct);
      int idx = 0;
      int cyc = 0;
      while (idx < n && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         ordy[s] = 1'b0;
         if (cyc == 1) begin
            chk("load_in_ready", ir[s], 1'b1);
            chk("load_out_valid", ov[s], 1'b0);
         end
         if (cyc > 1 && int'($urandom_range(99)) < gap_pct) begin
            iv[s] = 1'b0;
         end else begin
            iv[s] = 1'b1;
            idat[s] = blk[idx];
            if (ir[s]) idx++;
         end
      end
      if (idx < n) chk("send_timeout", idx, n);
   endtask

   // Waits for out_valid (junk bytes offered meanwhile), checks latency and
   // digest, optionally holds off out_ready, then offers out_ready for one edge.
   task automatic wait_digest(input int s, input logic [23:0] expv, input int hold);
      int k = 0;
      logic [23:0] snap;
      do begin
         @(negedge clk);
         k++;
         iv[s] = 1'b1;
         idat[s] = 8'($urandom_range(255));
         ordy[s] = 1'b0;
         if (k == 1) begin
            chk("run_busy", bsy[s], 1'b1);
            chk("run_in_ready", ir[s], 1'b0);
         end
      end while (!ov[s] && k < 200);
      iv[s] = 1'b0;
      chk("latency", k, rounds_of(s) + 1);
      chk("digest", dig[s], expv);
      snap = dig[s];
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", ov[s], 1'b1);
         chk("hold_digest", dig[s], snap);
         chk("hold_busy", bsy[s], 1'b0);
      end
      ordy[s] = 1'b1;
      $display("digest dut%0d rounds=%0d observed=%h expected=%h latency=%0d", s, rounds_of(s), dig[s], expv, k);
   endtask

   initial begin
      rst_n = 1'b0; iv = '0; ordy = '0; idat = '0;
      do_reset();

      // ROUNDS=2, all-zero block
      for (int i = 0; i < 16; i++) blk[i] = 8'h00;
      send_block(0, 16, 0);
      wait_digest(0, 24'h08FF30, 0);

      // ROUNDS=2, M[0]=1
      blk[0] = 8'h01;
      send_block(0, 16, 0);
      wait_digest(0, 24'h090F30, 0);
      @(negedge clk);
      ordy[0] = 1'b0;
      chk("ack_out_valid", ov[0], 1'b0);
      chk("ack_digest_kept", dig[0], 24'h090F30);

      // ROUNDS=32, random gaps, out_ready held low for 10 cycles
      rand_block();
      exp_d = model(blk, 32);
      send_block(1, 16, 40);
      wait_digest(1, exp_d, 10);

      // Reset mid-RUN
      rand_block();
      send_block(1, 16, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         iv[1] = 1'b0;
      end
      chk("midrun_busy", bsy[1], 1'b1);
      do_reset();
      begin
         int spurious = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov[1]) spurious++;
         end
         chk("no_spurious_valid", spurious, 0);
      end

      // Reset mid-LOAD after 7 bytes, then a fresh block
      rand_block();
      send_block(1, 7, 20);
      do_reset();
      rand_block();
      exp_d = model(blk, 32);
      send_block(1, 16, 25);
      wait_digest(1, exp_d, 0);

      // Back-to-back blocks with immediate acceptance
      rand_block();
      exp_d = model(blk, 32);
      send_block(1, 16, 0);
      wait_digest(1, exp_d, 0);
      rand_block();
      exp_d = model(blk, 32);
      send_block(1, 16, 0);
      wait_digest(1, exp_d, 0);
      @(negedge clk);
      ordy[1] = 1'b0;
      chk("final_out_valid", ov[1], 1'b0);
      chk("final_in_ready", ir[1], 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/hash_round_ctrl.md
# hash_round_ctrl

Iterative controller for the 8-bit three-register compression round pair (type-1 round: x = a ^ b, K = 8'h99; type-2 round: x = a | b, K = 8'hA1). It sits directly upstream of the round logic. It does the following:
- accepts a 16-byte message block over a valid/ready byte stream;
- expands it into the per-round W schedule;
- sequences ROUNDS rounds, chaining a/b/c between them;
- emits a 24-bit digest over a valid/ready handshake.

The round datapath is instantiated or replicated internally with exactly the round equations below.

## Interface
- ROUNDS, 32: number of rounds. Must be even, in the range 2..32. Rounds 0..ROUNDS/2-1 are type-1; rounds ROUNDS/2..ROUNDS-1 are type-2.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  message byte valid.
- in_ready  out  1  block accepts a byte this cycle.
- in_data  in  8  message byte. The first accepted byte is M[0], the 16th is M[15].
- out_valid  out  1  digest valid.
- out_ready  in  1  consumer accepts the digest.
- digest  out  24  {A, B, C}; A is bits 23:16.
- busy  out  1  high in RUN.

## Operation
- States: LOAD, RUN, DONE. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready writes in_data into window slot byte_cnt and increments byte_cnt (4 bits).
  - Accepting the byte at byte_cnt=15 does all of the following on the same edge: goes to RUN, sets a=8'h67, b=8'hEF, c=8'h98, round=0.
- RUN:
  - in_ready=0, busy=1.
  - One round per cycle, using W = w[0] (window slot 0).
  - Round update, all 8-bit with carries discarded:
    - a' = b ^ c
    - b' = c << 4 (low nibble zero)
    - c' = x + K + W
  - x and K are chosen by round type as defined above.
  - Window shift each round: w[i] <= w[i+1] for i=0..14; w[15] <= rotl1(w[13] ^ w[8] ^ w[2] ^ w[0]).
    - Rotate-left by 1: bit7 moves to bit0.
    - This gives W[t] = M[t] for t<16 and W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]) for t>=16.
  - On the round=ROUNDS-1 edge:
    - digest <= {a'+8'h67, b'+8'hEF, c'+8'h98}, each mod 256;
    - go to DONE.
- DONE:
  - out_valid=1, in_ready=0, busy=0.
  - digest is held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: go to LOAD and clear byte_cnt. digest keeps its value.
- in_valid while not in LOAD is ignored; no data is captured.

## Timing
- Reset values after an edge with rst_n=0:
  - state=LOAD, byte_cnt=0, round=0, a/b/c=0, window=0;
  - digest=24'h0, out_valid=0, busy=0;
  - in_ready=1 (combinational from state).
- in_ready, out_valid and busy are decoded from registered state only. No combinational path from in_valid or out_ready to any output.
- Latency: the 16th byte is accepted at edge E. Rounds 0..ROUNDS-1 execute at edges E+1..E+ROUNDS. out_valid is high starting in the cycle after edge E+ROUNDS.
- Gaps (in_valid low) during LOAD stall byte_cnt; partial blocks are retained indefinitely.
- Digest accepted at edge D: in_ready=1 in the following cycle. Minimum block period is 16+ROUNDS+1 cycles.
- rst_n low in any state, including mid-LOAD or mid-RUN: the state is discarded and reset values apply at that edge. No digest is produced for the interrupted block.
- out_ready high while not in DONE has no effect.

## Test plan
- Reset with all outputs X-checked:
  - rst_n=0 for 2 cycles → digest=0, out_valid=0, busy=0;
  - in_ready=1 in the first cycle after rst_n rises.
- ROUNDS=2, 16 zero bytes, out_ready=1:
  - digest=24'h08FF30;
  - out_valid rises exactly 3 cycles after the 16th accepted edge.
- ROUNDS=2, M[0]=8'h01, rest zero → digest=24'h090F30.
- Backpressure, ROUNDS=32:
  - random in_valid gaps → digest equals the golden software model;
  - out_ready held low 10 cycles → digest and out_valid stable; busy=0.
- Reset mid-RUN, then reset mid-LOAD after 7 bytes, then a full fresh block:
  - no spurious out_valid;
  - the fresh block's digest matches the model, proving byte_cnt and the window restarted at 0.
- Back-to-back blocks with out_ready=1:
  - the second block's first byte is accepted the cycle after the digest handshake;
  - both digests match the model, confirming no state leaks between blocks.
